// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the oversampled UART receiver.
//   rx_state_e  - receiver FSM state encoding
//   PARITY_*    - parity-mode selector values for PARITY_O_1
//   exp_parity  - expected parity bit from the XOR-reduction of the data
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

   localparam int PARITY_EVEN = 0;
   localparam int PARITY_ODD  = 1;

   // Even parity: parity bit equals the XOR of the data bits.
   // Odd parity: parity bit is the inverse of that XOR.
   function automatic logic exp_parity(input logic red_xor, input int mode);
      return (mode == PARITY_ODD) ? ~red_xor : red_xor;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
//   clk     - system clock
//   arst    - asynchronous active-high reset (flops reset to line-idle 1)
//   rx_i    - raw asynchronous serial input
//   rx_s_o  - synchronized serial input
module uart_rx_sync (
   input  logic clk,
   input  logic arst,
   input  logic rx_i,
   output logic rx_s_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= rx_i;
         sync_q <= meta_q;
      end
   end

   assign rx_s_o = sync_q;

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: UART receiver, 1 start, D_WIDTH data (LSB first), 1 parity,
// 1 stop bit, one bit period = CLK_FREQ_MHZ clock cycles.
//   clk        - system clock
//   arst       - asynchronous active-high reset
//   Rx         - asynchronous serial line, idle high
//   rx_ready   - consumer accepts the held frame
//   rx_valid   - a frame is held on data_out with its error flags
//   data_out   - received data word
//   parity_err - held frame failed the parity check
//   frame_err  - held frame had a 0 stop bit
//   overrun    - one-cycle pulse when a completed frame is dropped
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int D_WIDTH      = 8,
   parameter int PARITY_O_1   = 0,
   parameter int CLK_FREQ_MHZ = 50
) (
   input  logic               clk,
   input  logic               arst,
   input  logic               Rx,
   input  logic               rx_ready,
   output logic               rx_valid,
   output logic [D_WIDTH-1:0] data_out,
   output logic               parity_err,
   output logic               frame_err,
   output logic               overrun
);

   localparam int CW = $clog2(CLK_FREQ_MHZ + 1);
   localparam int BW = $clog2(D_WIDTH + 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_FREQ_MHZ / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_FREQ_MHZ - 1);
   localparam logic [BW-1:0] BITS_LAST = BW'(D_WIDTH - 1);

   logic rx_s;

   uart_rx_sync u_sync (
      .clk    (clk),
      .arst   (arst),
      .rx_i   (Rx),
      .rx_s_o (rx_s)
   );

   rx_state_e          state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [BW-1:0]      bits_q, bits_d;
   logic [D_WIDTH-1:0] shift_q, shift_d;
   logic               perr_q, perr_d;       // parity result of the frame in flight
   logic               rx_prev_q;
   logic               valid_q, valid_d;
   logic [D_WIDTH-1:0] dout_q, dout_d;
   logic               pe_q, pe_d;
   logic               fe_q, fe_d;
   logic               ovr_q, ovr_d;
   logic               frame_done;
   logic               frame_ferr;

   // Falling edge only: a line held low after a bad stop bit never restarts.
   wire fall = rx_prev_q & ~rx_s;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bits_q    <= '0;
         shift_q   <= '0;
         perr_q    <= 1'b0;
         rx_prev_q <= 1'b1;
         valid_q   <= 1'b0;
         dout_q    <= '0;
         pe_q      <= 1'b0;
         fe_q      <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bits_q    <= bits_d;
         shift_q   <= shift_d;
         perr_q    <= perr_d;
         rx_prev_q <= rx_s;
         valid_q   <= valid_d;
         dout_q    <= dout_d;
         pe_q      <= pe_d;
         fe_q      <= fe_d;
         ovr_q     <= ovr_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      bits_d     = bits_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      frame_done = 1'b0;
      frame_ferr = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            bits_d = '0;
            if (fall) state_d = START;
         end
         START: begin
            // Mid-start-bit recheck rejects glitches shorter than half a bit.
            if (cnt_q == HALF_LAST) begin
               cnt_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d              = '0;
               shift_d            = shift_q >> 1;
               shift_d[D_WIDTH-1] = rx_s;
               bits_d             = bits_q + 1'b1;
               if (bits_q == BITS_LAST) state_d = PARITY;
            end
         end
         PARITY: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               perr_d  = rx_s != exp_parity(^shift_q, PARITY_O_1);
               state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d      = '0;
               frame_done = 1'b1;
               frame_ferr = ~rx_s;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output holding register: a completed frame loads when the slot is
   // empty or being accepted this cycle; otherwise it is dropped.
   always_comb begin
      valid_d = valid_q;
      dout_d  = dout_q;
      pe_d    = pe_q;
      fe_d    = fe_q;
      ovr_d   = 1'b0;

      if (frame_done) begin
         if (!valid_q || rx_ready) begin
            valid_d = 1'b1;
            dout_d  = shift_q;
            pe_d    = perr_q;
            fe_d    = frame_ferr;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && rx_ready) begin
         valid_d = 1'b0;
      end
   end

   assign rx_valid   = valid_q;
   assign data_out   = dout_q;
   assign parity_err = pe_q;
   assign frame_err  = fe_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
`timescale 1ns/1ps
module tb_uart_rx_os;

   localparam int CPB = 50;

   logic       clk = 1'b0;
   logic       arst;
   logic       Rx;
   logic       rx_ready;
   logic       rx_valid;
   logic [7:0] data_out;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;

   always #5 clk = ~clk;

   uart_rx_os #(.D_WIDTH(8), .PARITY_O_1(0), .CLK_FREQ_MHZ(50)) dut (
      .clk        (clk),
      .arst       (arst),
      .Rx         (Rx),
      .rx_ready   (rx_ready),
      .rx_valid   (rx_valid),
      .data_out   (data_out),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun)
   );

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } frm_t;

   frm_t exp_q[$];
   frm_t got_q[$];
   int   checks = 0;
   int   errors = 0;
   int   ov_cnt = 0;
   logic pv = 1'b0;

   // Protocol monitor: a frame is newly presented when rx_valid is seen
   // after an empty slot or after a handshake on the previous edge.
   always @(posedge clk) begin
      #1;
      if (rx_valid && (!pv || rx_ready))
         got_q.push_back('{data_out, parity_err, frame_err});
      if (overrun) ov_cnt++;
      pv = rx_valid;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      Rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Drives one frame; bad_par flips the parity bit, stop is the stop bit.
   // rst_bit >= 0 pulses arst in the middle of that line bit and aborts.
   task automatic send(input logic [7:0] d, input logic bad_par, input logic stop,
                       input int rst_bit, input logic deliver);
      logic [10:0] bits;
      bits = {stop, (^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         Rx = bits[i];
         if (i == rst_bit) begin
            repeat (20) @(negedge clk);
            arst = 1'b1;
            repeat (3) @(negedge clk);
            chk("rst rx_valid", rx_valid, 0);
            chk("rst data_out", data_out, 0);
            chk("rst parity_err", parity_err, 0);
            chk("rst frame_err", frame_err, 0);
            chk("rst overrun", overrun, 0);
            arst = 1'b0;
            Rx   = 1'b1;
            return;
         end
         repeat (CPB) @(negedge clk);
      end
      Rx = 1'b1;
      if (deliver) exp_q.push_back('{d, bad_par, ~stop});
   endtask

   task automatic compare_frames(input string tag);
      frm_t g, e;
      chk({tag, " count"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, " data"}, g.d, e.d);
         chk({tag, " parity_err"}, g.pe, e.pe);
         chk({tag, " frame_err"}, g.fe, e.fe);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int ov0;
      arst = 1'b1; Rx = 1'b1; rx_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset rx_valid", rx_valid, 0);
      chk("reset data_out", data_out, 0);
      chk("reset parity_err", parity_err, 0);
      chk("reset frame_err", frame_err, 0);
      chk("reset overrun", overrun, 0);
      arst = 1'b0;
      idle(10);

      // Clean frame
      send(8'hA5, 1'b0, 1'b1, -1, 1'b1); idle(20);
      compare_frames("a5");

      // Wrong parity bit (0 sent, 1 expected)
      send(8'h01, 1'b1, 1'b1, -1, 1'b1); idle(20);
      compare_frames("01");

      // Bad stop bit, then line held low: no retrigger
      send(8'h3C, 1'b0, 1'b0, -1, 1'b1);
      Rx = 1'b0;
      repeat (600) @(negedge clk);
      compare_frames("3c held low");
      idle(60);

      // Short low glitch is rejected
      Rx = 1'b0;
      repeat (10) @(negedge clk);
      idle(100);
      compare_frames("glitch");

      // Random frames with occasional parity/stop corruption
      for (int k = 0; k < 6; k++) begin
         send(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), -1, 1'b1);
         idle($urandom_range(0, 30));
      end
      idle(20);
      compare_frames("random");

      // Overrun: second frame dropped while first is held
      ov0 = ov_cnt;
      rx_ready = 1'b0;
      send(8'h11, 1'b0, 1'b1, -1, 1'b1);
      send(8'h22, 1'b0, 1'b1, -1, 1'b0);
      idle(20);
      chk("ovr data_out held", data_out, 8'h11);
      chk("ovr rx_valid held", rx_valid, 1);
      chk("ovr pulses", ov_cnt - ov0, 1);
      rx_ready = 1'b1;
      @(posedge clk); #1;
      chk("ovr rx_valid clears", rx_valid, 0);
      @(negedge clk);
      compare_frames("ovr");

      // Reset during the 4th data bit aborts; next frame is clean
      send(8'hC3, 1'b0, 1'b1, 4, 1'b0);
      idle(600);
      compare_frames("abort");
      send(8'h5A, 1'b0, 1'b1, -1, 1'b1); idle(20);
      compare_frames("5a");
      chk("overrun total", ov_cnt - ov0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
